// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the default operand width.
package serial_sub_pkg;

  localparam int unsigned SERSUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full-subtractor cell: D = A - B - Bin, Bout is the borrow out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  // Difference and borrow for one bit position
  always_comb begin
    D    = A ^ B ^ Bin;
    Bout = (~A & B) | (~(A ^ B) & Bin);
  end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock,
// behind a start/busy/done handshake.
// Optional: define SERSUB_OVERFLOW_EN to add a registered signed overflow
// output updated together with diff.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SERSUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERSUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned    CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERSUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;

  full_subtractor u_cell (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Bin  (bin_q),
    .D    (cell_d),
    .Bout (cell_bout)
  );

  // Flag the cycle that processes the operand MSB
  always_comb begin
    last_bit = (cnt_q == LAST_BIT);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE accepts a new start directly for back-to-back use
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? SHIFT : IDLE;
      SHIFT:      state_d = last_bit ? DONE : SHIFT;
      default:    state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  // Datapath next values: capture on accept, shift one bit per SHIFT cycle
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    part_d   = part_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERSUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d = a;
          b_sh_d = b;
          part_d = '0;
          bin_d  = 1'b0;
          cnt_d  = '0;
        end
      end
      SHIFT: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        part_d = {cell_d, part_q[WIDTH-1:1]};
        bin_d  = cell_bout;
        cnt_d  = cnt_q + 1'b1;
        if (last_bit) begin
          // Result is taken from the shifted value so the MSB lands this edge
          diff_d   = {cell_d, part_q[WIDTH-1:1]};
          borrow_d = cell_bout;
`ifdef SERSUB_OVERFLOW_EN
          ovf_d    = (a_sh_q[0] != b_sh_q[0]) && (cell_d != a_sh_q[0]);
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      part_q   <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERSUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      part_q   <= part_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERSUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Result outputs
  always_comb begin
    diff       = diff_q;
    borrow_out = borrow_q;
`ifdef SERSUB_OVERFLOW_EN
    overflow   = ovf_q;
`endif
  end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERSUB_OVERFLOW_EN
  logic         overflow;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
`ifdef SERSUB_OVERFLOW_EN
    .overflow   (overflow),
`endif
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a_i),
    .b          (b_i),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef SERSUB_OVERFLOW_EN
    check(tag, 32'(overflow), 32'(exp));
`else
    if (exp === 1'bx) $display("unreachable %s", tag);
`endif
  endtask

  // Drive operands with start high for one edge; operands are scrambled afterwards
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    a_i   = av;
    b_i   = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_i   = ~av;
    b_i   = av ^ bv;
  endtask

  // Advance until done is seen (bounded); edges/busy counts continue from e0/b0
  task automatic wait_done(input int e0, input int b0, output int edges, output int bcnt,
                           output bit seen);
    edges = e0;
    bcnt  = b0;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      edges++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int e, bc;
    bit s;
    issue(av, bv);
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    wait_done(1, 1, e, bc, s);
    check({tag, "_done_seen"}, 32'(s), 32'd1);
    check({tag, "_latency"}, 32'(e), 32'(W + 1));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(W));
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
    check_ovf({tag, "_ovf"}, eo);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_diff_hold"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    int e, bc, dcount;
    bit s;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    check_ovf("rst_ovf", 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("5m3",  8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op("3m5",  8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op("80m1", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("0m0",  8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    // Start pulse during SHIFT is ignored
    issue(8'hFF, 8'h0F);
    @(posedge clk); #1;
    a_i = 8'h01; b_i = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, 3, e, bc, s);
    check("ign_done_seen", 32'(s), 32'd1);
    check("ign_latency", 32'(e), 32'(W + 1));
    check("ign_busy_cycles", 32'(bc), 32'(W));
    check("ign_diff", 32'(diff), 32'hF0);
    check("ign_borrow", 32'(borrow_out), 32'd0);
    check_ovf("ign_ovf", 1'b0);

    // Back-to-back: start asserted during DONE is accepted on that edge
    a_i = 8'h10; b_i = 8'h20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_i = 8'hAA; b_i = 8'h55;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done_low", 32'(done), 32'd0);
    check("b2b_diff_held", 32'(diff), 32'hF0);
    wait_done(1, 1, e, bc, s);
    check("b2b_done_seen", 32'(s), 32'd1);
    check("b2b_latency", 32'(e), 32'(W + 1));
    check("b2b_diff", 32'(diff), 32'hF0);
    check("b2b_borrow", 32'(borrow_out), 32'd1);
    check_ovf("b2b_ovf", 1'b0);
    @(posedge clk); #1;

    // Reset on cycle 4 of an operation aborts it
    issue(8'h33, 8'h11);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow_out), 32'd0);
    check_ovf("abort_ovf", 1'b0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);

    run_op("fresh", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_serial_subtractor
